// File: rtl/edge_overlay.sv
// Composites delayed raw RGB with the Sobel edge stream (raw / edge grey / overlay / overlay on dimmed raw).
// Latency 2 cycles from edge-stream inputs; no backpressure, both streams free-run and the FIFO flags over/underflow.
module edge_overlay #(
   parameter int                    COLORDEPTH = 8,
   parameter int                    DEPTH      = 4096,
   parameter logic [COLORDEPTH-1:0] OVL_R      = 8'hFF,
   parameter logic [COLORDEPTH-1:0] OVL_G      = 8'h00,
   parameter logic [COLORDEPTH-1:0] OVL_B      = 8'h00
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [1:0]            mode_i,
   input  logic [COLORDEPTH-1:0] thr_i,
   input  logic [COLORDEPTH-1:0] red_i,
   input  logic [COLORDEPTH-1:0] green_i,
   input  logic [COLORDEPTH-1:0] blue_i,
   input  logic                  dv_i,
   input  logic                  vs_i,
   input  logic [COLORDEPTH-1:0] edge_i,
   input  logic                  edge_dv_i,
   input  logic                  edge_hs_i,
   input  logic                  edge_vs_i,
   output logic [COLORDEPTH-1:0] red_o,
   output logic [COLORDEPTH-1:0] green_o,
   output logic [COLORDEPTH-1:0] blue_o,
   output logic                  dv_o,
   output logic                  hs_o,
   output logic                  vs_o,
   output logic                  ovf_o,
   output logic                  udf_o,
   output logic                  sync_err_o
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic                  sof;
      logic [COLORDEPTH-1:0] r;
      logic [COLORDEPTH-1:0] g;
      logic [COLORDEPTH-1:0] b;
   } ent_t;

   ent_t ram [DEPTH];
   ent_t rd_ent_q;
   ent_t wr_ent;
   ent_t raw;

   logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]           level_q, level_d;
   logic                  vs_prev_q, vs_prev_d, sof_pend_q, sof_pend_d;
   logic                  evs_prev_q, evs_prev_d, esof_pend_q, esof_pend_d;
   logic                  first_q, first_d;
   logic [COLORDEPTH-1:0] thr_l_q, thr_l_d;
   logic [1:0]            mode_l_q, mode_l_d;
   logic [COLORDEPTH-1:0] edge_q, edge_d;
   logic                  edv_q, edv_d, ehs_q, ehs_d, evs_q, evs_d, esof_q, esof_d;
   logic                  rd_ok_q, rd_ok_d;
   logic                  ovf_q, ovf_d, udf_q, udf_d, sync_err_q, sync_err_d;
   logic [COLORDEPTH-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic                  dv_q, dv_d, hs_q, hs_d, vs_q, vs_d;

   logic vs_rise, evs_rise, sof_tag, esof_tag, full, empty, wr_ok, rd_ok, hit;

   always_comb begin
      vs_rise  = vs_i & ~vs_prev_q;
      evs_rise = edge_vs_i & ~evs_prev_q;
      sof_tag  = dv_i & (sof_pend_q | vs_rise);
      esof_tag = edge_dv_i & (esof_pend_q | evs_rise);
      full     = (level_q == (AW+1)'(DEPTH));
      empty    = (level_q == '0);
      rd_ok    = edge_dv_i & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
      wr_ok    = dv_i & (~full | edge_dv_i);
      wr_ent   = '{sof: sof_tag, r: red_i, g: green_i, b: blue_i};

      vs_prev_d   = vs_i;
      evs_prev_d  = edge_vs_i;
      sof_pend_d  = dv_i ? 1'b0 : (sof_pend_q | vs_rise);
      esof_pend_d = edge_dv_i ? 1'b0 : (esof_pend_q | evs_rise);

      wr_ptr_d = wr_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = rd_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
      level_d  = level_q;
      if (wr_ok && !rd_ok) level_d = level_q + (AW+1)'(1);
      if (!wr_ok && rd_ok) level_d = level_q - (AW+1)'(1);

      ovf_d = ovf_q | (dv_i & ~wr_ok);
      udf_d = udf_q | (edge_dv_i & empty);

      first_d  = 1'b0;
      thr_l_d  = thr_l_q;
      mode_l_d = mode_l_q;
      if (first_q || evs_rise) begin
         thr_l_d  = thr_i;
         mode_l_d = mode_i;
      end

      edge_d  = edge_i;
      edv_d   = edge_dv_i;
      ehs_d   = edge_hs_i;
      evs_d   = edge_vs_i;
      esof_d  = esof_tag;
      rd_ok_d = rd_ok;
   end

   // Stage 2: an underflowed pop reads back as an all-zero, untagged entry.
   always_comb begin
      raw        = rd_ok_q ? rd_ent_q : '0;
      sync_err_d = sync_err_q | (edv_q & (esof_q != raw.sof));
      hit        = (edge_q >= thr_l_q);
      red_d      = raw.r;
      green_d    = raw.g;
      blue_d     = raw.b;
      case (mode_l_q)
         2'd0: ;
         2'd1: begin
            red_d   = edge_q;
            green_d = edge_q;
            blue_d  = edge_q;
         end
         2'd2: if (hit) begin
            red_d   = OVL_R;
            green_d = OVL_G;
            blue_d  = OVL_B;
         end
         default: begin
            red_d   = hit ? OVL_R : raw.r >> 1;
            green_d = hit ? OVL_G : raw.g >> 1;
            blue_d  = hit ? OVL_B : raw.b >> 1;
         end
      endcase
      if (!edv_q) begin
         red_d   = '0;
         green_d = '0;
         blue_d  = '0;
      end
      dv_d = edv_q;
      hs_d = ehs_q;
      vs_d = evs_q;
   end

   always_ff @(posedge clk) begin
      if (wr_ok && !rst) ram[wr_ptr_q] <= wr_ent;
      rd_ent_q <= ram[rd_ptr_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         vs_prev_q   <= 1'b0;
         evs_prev_q  <= 1'b0;
         sof_pend_q  <= 1'b0;
         esof_pend_q <= 1'b0;
         first_q     <= 1'b1;
         thr_l_q     <= '0;
         mode_l_q    <= '0;
         edge_q      <= '0;
         edv_q       <= 1'b0;
         ehs_q       <= 1'b0;
         evs_q       <= 1'b0;
         esof_q      <= 1'b0;
         rd_ok_q     <= 1'b0;
         ovf_q       <= 1'b0;
         udf_q       <= 1'b0;
         sync_err_q  <= 1'b0;
         red_q       <= '0;
         green_q     <= '0;
         blue_q      <= '0;
         dv_q        <= 1'b0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         vs_prev_q   <= vs_prev_d;
         evs_prev_q  <= evs_prev_d;
         sof_pend_q  <= sof_pend_d;
         esof_pend_q <= esof_pend_d;
         first_q     <= first_d;
         thr_l_q     <= thr_l_d;
         mode_l_q    <= mode_l_d;
         edge_q      <= edge_d;
         edv_q       <= edv_d;
         ehs_q       <= ehs_d;
         evs_q       <= evs_d;
         esof_q      <= esof_d;
         rd_ok_q     <= rd_ok_d;
         ovf_q       <= ovf_d;
         udf_q       <= udf_d;
         sync_err_q  <= sync_err_d;
         red_q       <= red_d;
         green_q     <= green_d;
         blue_q      <= blue_d;
         dv_q        <= dv_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
      end
   end

   assign red_o      = red_q;
   assign green_o    = green_q;
   assign blue_o     = blue_q;
   assign dv_o       = dv_q;
   assign hs_o       = hs_q;
   assign vs_o       = vs_q;
   assign ovf_o      = ovf_q;
   assign udf_o      = udf_q;
   assign sync_err_o = sync_err_q;
endmodule

// File: tb/tb_edge_overlay.sv
// Bench for edge_overlay: directed frames with randomized pixels checked every cycle against a queue-based model.
module tb_edge_overlay;
   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] mode_i;
   logic [7:0] thr_i, red_i, green_i, blue_i, edge_i;
   logic       dv_i, vs_i, edge_dv_i, edge_hs_i, edge_vs_i;
   logic [7:0] red_o, green_o, blue_o;
   logic       dv_o, hs_o, vs_o, ovf_o, udf_o, sync_err_o;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   edge_overlay #(.COLORDEPTH(8), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .mode_i(mode_i), .thr_i(thr_i),
      .red_i(red_i), .green_i(green_i), .blue_i(blue_i),
      .dv_i(dv_i), .vs_i(vs_i), .edge_i(edge_i),
      .edge_dv_i(edge_dv_i), .edge_hs_i(edge_hs_i), .edge_vs_i(edge_vs_i),
      .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
      .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o),
      .ovf_o(ovf_o), .udf_o(udf_o), .sync_err_o(sync_err_o)
   );

   always #5 clk = ~clk;

   // Reference model: a pixel queue plus frame-start bookkeeping.
   typedef struct packed {
      logic       sof;
      logic [7:0] r, g, b;
   } pix_t;

   pix_t        mq[$];
   logic        m_vsp, m_evsp, m_pend, m_epend, m_first;
   logic [7:0]  m_thr;
   logic [1:0]  m_mode;
   logic        m_ovf, m_udf, m_sync, m_sync_nx;
   logic [26:0] m_s1, m_out;

   task automatic model_step();
      logic       rise, erise, tag, etag;
      pix_t       popped;
      logic [7:0] r, g, b;
      logic       hit;
      if (rst) begin
         mq.delete();
         {m_vsp, m_evsp, m_pend, m_epend} = '0;
         m_first = 1'b1;
         m_thr = '0;
         m_mode = '0;
         {m_ovf, m_udf, m_sync, m_sync_nx} = '0;
         m_s1 = '0;
         m_out = '0;
         return;
      end
      rise  = vs_i & ~m_vsp;
      erise = edge_vs_i & ~m_evsp;
      tag   = dv_i & (m_pend | rise);
      etag  = edge_dv_i & (m_epend | erise);
      m_pend  = dv_i ? 1'b0 : (m_pend | rise);
      m_epend = edge_dv_i ? 1'b0 : (m_epend | erise);
      m_vsp  = vs_i;
      m_evsp = edge_vs_i;

      popped = '0;
      if (edge_dv_i) begin
         if (mq.size() == 0) m_udf = 1'b1;
         else popped = mq.pop_front();
      end
      if (dv_i) begin
         if (mq.size() < DEPTH) mq.push_back('{sof: tag, r: red_i, g: green_i, b: blue_i});
         else m_ovf = 1'b1;
      end

      m_sync    = m_sync | m_sync_nx;
      m_sync_nx = edge_dv_i && (etag != popped.sof);

      if (m_first || erise) begin
         m_thr  = thr_i;
         m_mode = mode_i;
      end
      m_first = 1'b0;

      hit = (edge_i >= m_thr);
      r = popped.r; g = popped.g; b = popped.b;
      if (m_mode == 2'd1) begin
         r = edge_i; g = edge_i; b = edge_i;
      end else if (m_mode >= 2'd2 && hit) begin
         r = 8'hFF; g = 8'h00; b = 8'h00;
      end else if (m_mode == 2'd3) begin
         r = popped.r / 2; g = popped.g / 2; b = popped.b / 2;
      end
      if (!edge_dv_i) begin
         r = 0; g = 0; b = 0;
      end
      m_out = m_s1;
      m_s1  = {r, g, b, edge_dv_i, edge_hs_i, edge_vs_i};
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      compared++;
      assert ({red_o, green_o, blue_o, dv_o, hs_o, vs_o} === m_out)
      else begin
         mismatched++;
         $error("FAIL out cyc=%0d got=%h exp=%h", cyc, {red_o, green_o, blue_o, dv_o, hs_o, vs_o}, m_out);
      end
      compared++;
      assert ({ovf_o, udf_o, sync_err_o} === {m_ovf, m_udf, m_sync})
      else begin
         mismatched++;
         $error("FAIL flags cyc=%0d got=%b exp=%b", cyc, {ovf_o, udf_o, sync_err_o}, {m_ovf, m_udf, m_sync});
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp)
      else begin
         mismatched++;
         $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   task automatic idle_inputs();
      {dv_i, vs_i, edge_dv_i, edge_hs_i, edge_vs_i} = '0;
      {red_i, green_i, blue_i, edge_i} = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
   endtask

   // kind 0: random pixels/edges/thr/mode; kind 1: alignment (edge 0x80, thr 0x40, mode 2);
   // kind 2: threshold boundary (edge 3F/40/41, thr 0x40, mode 3, fixed raw colour).
   task automatic frame(input int kind, input int len, input int dly, input int skew);
      logic dv_a [128];
      logic hs_a [128];
      int   n, k, s, ecnt;
      n = len + 4;
      ecnt = 0;
      for (int c = 0; c < 128; c++) begin
         dv_a[c] = (c == 4) || (c > 4 && c < n && $urandom_range(0, 3) != 0);
         hs_a[c] = (c % 8) == 7;
      end
      for (int c = 0; c < n + dly + 3; c++) begin
         k = c - dly;
         s = c - skew;
         dv_i      = (c < n) ? dv_a[c] : 1'b0;
         vs_i      = (s >= 0 && s <= 3);
         edge_dv_i = (k >= 0 && k < n) ? dv_a[k] : 1'b0;
         edge_hs_i = (k >= 0 && k < n) ? hs_a[k] : 1'b0;
         edge_vs_i = (k >= 0 && k <= 3);
         case (kind)
            1: begin
               red_i = 8'($urandom); green_i = 8'($urandom); blue_i = 8'($urandom);
               edge_i = 8'h80; thr_i = 8'h40; mode_i = 2'd2;
            end
            2: begin
               red_i = 8'h80; green_i = 8'h40; blue_i = 8'h20;
               edge_i = (ecnt % 3 == 0) ? 8'h3F : ((ecnt % 3 == 1) ? 8'h40 : 8'h41);
               thr_i = 8'h40; mode_i = 2'd3;
            end
            default: begin
               red_i = 8'($urandom); green_i = 8'($urandom); blue_i = 8'($urandom);
               edge_i = 8'($urandom); thr_i = 8'($urandom); mode_i = 2'($urandom);
            end
         endcase
         if (edge_dv_i) ecnt++;
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      mode_i = '0;
      thr_i = '0;
      idle_inputs();

      do_reset();
      chk("reset_out", {red_o, green_o, blue_o, dv_o, hs_o, vs_o}, '0);
      chk("reset_flags", {ovf_o, udf_o, sync_err_o}, '0);

      frame(1, 40, 12, 0);
      frame(2, 30, 5, 0);
      chk("clean_flags_a", {ovf_o, udf_o, sync_err_o}, '0);
      for (int f = 0; f < 4; f++) frame(0, $urandom_range(20, 50), $urandom_range(3, 14), 0);
      chk("clean_flags_b", {ovf_o, udf_o, sync_err_o}, '0);

      // Overflow: 17 pushes into 16 entries, then 16 pops with mode latched to raw.
      idle_inputs();
      mode_i = 2'd0;
      thr_i = 8'h00;
      vs_i = 1'b1;
      tick();
      vs_i = 1'b0;
      for (int i = 0; i < 17; i++) begin
         dv_i = 1'b1;
         red_i = 8'($urandom); green_i = 8'($urandom); blue_i = 8'($urandom);
         tick();
      end
      idle_inputs();
      tick();
      chk("ovf_set", ovf_o, 1);
      edge_vs_i = 1'b1;
      tick();
      edge_vs_i = 1'b0;
      for (int i = 0; i < 16; i++) begin
         edge_dv_i = 1'b1;
         edge_i = 8'($urandom);
         tick();
      end
      idle_inputs();
      repeat (3) tick();
      chk("no_udf_yet", udf_o, 0);

      // Underflow with a simultaneous push, then pop the pushed pixel.
      dv_i = 1'b1; edge_dv_i = 1'b1;
      red_i = 8'h11; green_i = 8'h22; blue_i = 8'h33;
      tick();
      chk("udf_set", udf_o, 1);
      dv_i = 1'b0;
      tick();
      chk("udf_pixel", {red_o, green_o, blue_o, dv_o}, {24'h000000, 1'b1});
      edge_dv_i = 1'b0;
      tick();
      chk("pushed_pixel", {red_o, green_o, blue_o, dv_o}, {24'h112233, 1'b1});
      repeat (3) tick();

      // Sync error: raw vsync lags raw data by 5 cycles.
      do_reset();
      chk("flags_cleared", {ovf_o, udf_o, sync_err_o}, '0);
      frame(0, 30, 8, 5);
      chk("sync_err_set", sync_err_o, 1);
      idle_inputs();
      repeat (5) tick();
      chk("sync_err_sticky", sync_err_o, 1);
      do_reset();
      chk("sync_err_clear", sync_err_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
